// File: rtl/processor_pkg.sv
// Shared defaults for the processor register file and its scoreboard.
// Optional build macro: PROCESSOR_REGFILE_BYPASS_EN (write-to-read forwarding).
package processor_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    // Number of architectural registers addressed by an addr_w-bit index.
    function automatic int unsigned num_regs(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/processor_scoreboard.sv
// Pending-result scoreboard: one pending bit per register, a popcount of the
// pending vector, and per-read-port busy flags.
// Optional build macro: PROCESSOR_REGFILE_BYPASS_EN (busy cleared on forwarded reads).
module processor_scoreboard
    import processor_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned NUM_REGS = num_regs(ADDR_W)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    // Next pending vector: issue beats writeback on the same register; r0 never pends.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            if (issue_en && (issue_addr == ADDR_W'(r))) begin
                pend_d[r] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
                pend_d[r] = 1'b0;
            end
        end
        pend_d[0] = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            cnt_d = cnt_d + (ADDR_W + 1)'(pend_d[r]);
        end
    end

    // Pending bits and count; count tracks the new vector so it never lags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Per-port busy from the registered pending bits.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_busy[i] = pend_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef PROCESSOR_REGFILE_BYPASS_EN
            // Result is being forwarded this cycle, unless a fresh issue re-claims it.
            if (wr_en && (wr_addr != '0) && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr) &&
                !(issue_en && (issue_addr == wr_addr))) begin
                rd_busy[i] = 1'b0;
            end
`endif
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: rtl/processor_regfile_mp.sv
// Multi-read-port register file with r0 hardwired to zero and a pending-result
// scoreboard that stalls reads of registers awaiting writeback.
// Optional build macro: PROCESSOR_REGFILE_BYPASS_EN (same-cycle write forwarding).
module processor_regfile_mp
    import processor_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int unsigned NUM_REGS = num_regs(ADDR_W);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Register storage; r0 is never written so it stays at its reset value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports with optional forwarding of the in-flight write.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (rd_addr[i*ADDR_W +: ADDR_W] != '0) begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
            end
`ifdef PROCESSOR_REGFILE_BYPASS_EN
            if (wr_en && (wr_addr != '0) && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr)) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
            end
`endif
        end
    end

    processor_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .pend_cnt   (pend_cnt)
    );

    assign stall = |rd_busy;

endmodule

// File: tb/tb_processor_regfile_mp.sv
// Directed bench for processor_regfile_mp (default parameters). Expectations
// follow PROCESSOR_REGFILE_BYPASS_EN when it is defined for the build.
module tb_processor_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
`ifdef PROCESSOR_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             stall;
    logic [AW:0]      pend_cnt;

    always #5 clock = ~clock;

    processor_regfile_mp dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .stall      (stall),
        .pend_cnt   (pend_cnt)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] model [32];

    task automatic push(input string tag, input logic [63:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_cmp(input logic [63:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %0h required a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] rd(input int p);
        return 64'(rd_data[p*DW +: DW]);
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    task automatic do_issue(input logic [AW-1:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
        tick();
        issue_en = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) model[r] = '0;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; rd_addr = '0;
        #1 reset = 1'b0;
        #2;
        push("rst_pend", 64'd0); push("rst_stall", 64'd0); push("rst_rd0", 64'd0);
        pop_cmp(64'(pend_cnt)); pop_cmp(64'(stall)); pop_cmp(rd(0));
        tick();
        reset = 1'b1;

        // Write r3 with a same-cycle read.
        rd_addr    = {5'd0, 5'd3};
        wr_en      = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        #2;
        push("wr_cycle_rd0", BYP ? 64'hDEADBEEF : 64'd0);
        pop_cmp(rd(0));
        tick();
        wr_en = 1'b0; model[3] = 32'hDEADBEEF;
        #2;
        push("post_wr_rd0", 64'hDEADBEEF);
        pop_cmp(rd(0));

        // r0 is hardwired zero and never pending.
        do_write(5'd0, 32'h1234);
        rd_addr = {5'd3, 5'd0};
        #2;
        push("r0_read", 64'd0); push("r3_port1", 64'hDEADBEEF);
        pop_cmp(rd(0)); pop_cmp(rd(1));
        do_issue(5'd0);
        #2;
        push("r0_issue_pend", 64'd0); push("r0_issue_stall", 64'd0);
        pop_cmp(64'(pend_cnt)); pop_cmp(64'(stall));

        // Several registers written, then read back in pairs.
        for (int i = 1; i <= 6; i++) do_write(AW'(2 * i), 32'hA000_0000 | (i * 32'h1111));
        for (int i = 1; i <= 6; i++) begin
            rd_addr = {AW'(2 * (7 - i)), AW'(2 * i)};
            #2;
            push("pair_p0", 64'(model[2 * i])); push("pair_p1", 64'(model[2 * (7 - i)]));
            pop_cmp(rd(0)); pop_cmp(rd(1));
            tick();
        end

        // Issue r5, read busy, then write it back.
        do_issue(5'd5);
        rd_addr = {5'd5, 5'd3};
        #2;
        push("busy_r5", 64'b10); push("stall_r5", 64'd1); push("pend_r5", 64'd1);
        pop_cmp(64'(rd_busy)); pop_cmp(64'(stall)); pop_cmp(64'(pend_cnt));
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555;
        #1;
        push("wb_cycle_busy", BYP ? 64'b00 : 64'b10);
        push("wb_cycle_rd1", BYP ? 64'h5555 : 64'd0);
        pop_cmp(64'(rd_busy)); pop_cmp(rd(1));
        tick();
        wr_en = 1'b0; model[5] = 32'h5555;
        #2;
        push("wb_busy", 64'b00); push("wb_pend", 64'd0); push("wb_rd1", 64'h5555);
        pop_cmp(64'(rd_busy)); pop_cmp(64'(pend_cnt)); pop_cmp(rd(1));

        // Simultaneous issue and writeback on a pending r7: issue wins.
        do_issue(5'd7);
        rd_addr  = {5'd0, 5'd7};
        issue_en = 1'b1; issue_addr = 5'd7;
        wr_en    = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #2;
        push("iw_cycle_busy", 64'b01); push("iw_cycle_rd0", BYP ? 64'h55 : 64'd0);
        pop_cmp(64'(rd_busy)); pop_cmp(rd(0));
        tick();
        issue_en = 1'b0; wr_en = 1'b0; model[7] = 32'h55;
        #2;
        push("iw_rd0", 64'h55); push("iw_busy", 64'b01); push("iw_pend", 64'd1);
        pop_cmp(rd(0)); pop_cmp(64'(rd_busy)); pop_cmp(64'(pend_cnt));
        do_write(5'd7, 32'h77);
        #2;
        push("r7_clr_pend", 64'd0);
        pop_cmp(64'(pend_cnt));

        // Issue every nonzero register back-to-back.
        for (int i = 1; i < 32; i++) do_issue(AW'(i));
        rd_addr = {5'd5, 5'd3};
        #2;
        push("all_pend", 64'd31); push("all_busy", 64'b11);
        pop_cmp(64'(pend_cnt)); pop_cmp(64'(rd_busy));
        do_issue(5'd4);
        #2;
        push("reissue_pend", 64'd31);
        pop_cmp(64'(pend_cnt));
        do_write(5'd4, 32'h44);
        #2;
        push("clr4_pend", 64'd30);
        pop_cmp(64'(pend_cnt));
        do_write(5'd4, 32'h45);
        #2;
        push("reclr4_pend", 64'd30);
        pop_cmp(64'(pend_cnt));

        // Reset asserted mid-issue with activity held on the inputs.
        issue_en = 1'b1; issue_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        reset = 1'b0;
        #2;
        push("mid_rst_pend", 64'd0); push("mid_rst_stall", 64'd0);
        push("mid_rst_rd0", 64'd0); push("mid_rst_rd1", 64'd0);
        pop_cmp(64'(pend_cnt)); pop_cmp(64'(stall)); pop_cmp(rd(0)); pop_cmp(rd(1));
        tick();
        tick();
        rd_addr = {5'd4, 5'd9};
        #1;
        push("in_rst_pend", 64'd0); push("in_rst_rd0", 64'd0); push("in_rst_busy", 64'd0);
        pop_cmp(64'(pend_cnt));
        pop_cmp(BYP ? 64'd0 : rd(0)); // bypass forwards the held write even in reset
        pop_cmp(64'(rd_busy[1]));
        issue_en = 1'b0; wr_en = 1'b0;
        reset = 1'b1;
        tick();
        #1;
        push("post_rst_pend", 64'd0); push("post_rst_rd0", 64'd0); push("post_rst_rd1", 64'd0);
        pop_cmp(64'(pend_cnt)); pop_cmp(rd(0)); pop_cmp(rd(1));
        do_issue(5'd2);
        rd_addr = {5'd0, 5'd2};
        #2;
        push("resume_pend", 64'd1); push("resume_busy", 64'b01);
        pop_cmp(64'(pend_cnt)); pop_cmp(64'(rd_busy));

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
